// File: rtl/flow_control_rx_if.sv
// flow_control_rx_if
//   Bundles the flit-side and downstream-side signals of the credit-based
//   receiver so the design and its surroundings connect through one port.
//   Parameters:
//     DATA_WIDTH  flit width
//     CNT_W       width of the occupancy count
//   Modports:
//     slave   receiver view (drives ready_in, credit_out, data_out,
//             valid_out, occupancy, overflow)
//     master  environment view (drives data_in, valid_in, ready_out)
interface flow_control_rx_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 4
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic                  ready_in;
    logic                  credit_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  ready_out;
    logic [CNT_W-1:0]      occupancy;
    logic                  overflow;

    modport slave (
        input  data_in, valid_in, ready_out,
        output ready_in, credit_out, data_out, valid_out, occupancy, overflow
    );

    modport master (
        output data_in, valid_in, ready_out,
        input  ready_in, credit_out, data_out, valid_out, occupancy, overflow
    );
endinterface

// File: rtl/flow_control_rx.sv
// flow_control_rx
//   Receive end of a credit-based link. Flits land in a DEPTH-entry
//   first-word-fall-through FIFO and leave through a valid/ready handshake.
//   Every freed entry is returned to the sender as a one-cycle credit pulse;
//   after reset DEPTH credits are issued because the sender starts at zero.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   flow_control_rx_if.slave:
//             data_in/valid_in/ready_in      flits from the sender
//             credit_out                     credit pulse to the sender
//             data_out/valid_out/ready_out   downstream handshake
//             occupancy                      entries held, 0..DEPTH
//             overflow                       sticky write-while-full flag
//   Build option:
//     FLOW_CONTROL_RX_OVF_CHECK_EN  when defined, a write while full sets the
//                                   sticky overflow flag; otherwise overflow
//                                   is tied to 0. The write is dropped either way.
module flow_control_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    flow_control_rx_if.slave   bus
);
    // state | meaning
    // INIT  | issuing the DEPTH initial credits after reset
    // RUN   | normal operation, one credit per freed entry
    typedef enum logic {INIT, RUN} state_t;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      occupancy;
    logic [CNT_W-1:0]      pending;
    logic [CNT_W-1:0]      init_cnt;
    logic                  ready;
    logic                  credit;
    logic                  overflow;
    state_t                state;
    state_t                next_state;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic owe;

    assign full  = (occupancy == CNT_W'(DEPTH));
    assign empty = (occupancy == '0);
    assign push  = bus.valid_in && ready && !full;
    assign pop   = !empty && bus.ready_out;
    assign owe   = (pending != '0);

    // Datapath storage is not reset; only the pointers are.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            ready     <= 1'b0;
        end else begin
            ready <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                occupancy <= occupancy + CNT_W'(1);
            end else if (pop && !push) begin
                occupancy <= occupancy - CNT_W'(1);
            end
        end
    end

    // Credit engine: pending starts at DEPTH so the initial credits fall out
    // of the same drain logic that returns credits for pops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            pending  <= CNT_W'(DEPTH);
            init_cnt <= '0;
            credit   <= 1'b0;
        end else begin
            state   <= next_state;
            credit  <= owe;
            pending <= pending + CNT_W'(pop) - CNT_W'(owe);
            if (state == INIT && owe) begin
                init_cnt <= init_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            INIT: if (init_cnt == CNT_W'(DEPTH)) next_state = RUN;
            RUN:  next_state = RUN;
            default: next_state = INIT;
        endcase
    end

`ifdef FLOW_CONTROL_RX_OVF_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (bus.valid_in && ready && full) begin
            overflow <= 1'b1;
        end
    end
`else
    assign overflow = 1'b0;
`endif

    assign bus.ready_in   = ready;
    assign bus.credit_out = credit;
    assign bus.data_out   = mem[rd_ptr];
    assign bus.valid_out  = !empty;
    assign bus.occupancy  = occupancy;
    assign bus.overflow   = overflow;
endmodule

// File: tb/tb_flow_control_rx.sv
module tb_flow_control_rx;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   credits;
    logic exp_ovf;

    flow_control_rx_if #(.DATA_WIDTH(DW), .CNT_W(CW)) bus ();

    flow_control_rx #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready_in"},   32'(bus.ready_in),   32'd0);
        check({tag, "_credit_out"}, 32'(bus.credit_out), 32'd0);
        check({tag, "_valid_out"},  32'(bus.valid_out),  32'd0);
        check({tag, "_occupancy"},  32'(bus.occupancy),  32'd0);
        check({tag, "_overflow"},   32'(bus.overflow),   32'd0);
    endtask

    // Releases reset and expects exactly DEPTH back-to-back credits.
    task automatic check_init_credits(input string tag);
        rst = 1'b0;
        credits = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            check({tag, "_credit"}, 32'(bus.credit_out), (i < DEPTH) ? 32'd1 : 32'd0);
            if (bus.credit_out) credits++;
        end
        check({tag, "_credit_count"}, 32'(credits), 32'(DEPTH));
        check({tag, "_ready_in"},     32'(bus.ready_in), 32'd1);
        check({tag, "_occupancy"},    32'(bus.occupancy), 32'd0);
    endtask

    task automatic push_flit(input logic [31:0] value);
        bus.data_in  = value;
        bus.valid_in = 1'b1;
        step();
        bus.valid_in = 1'b0;
    endtask

`ifdef FLOW_CONTROL_RX_OVF_CHECK_EN
    initial exp_ovf = 1'b1;
`else
    initial exp_ovf = 1'b0;
`endif

    initial begin
        rst           = 1'b1;
        bus.data_in   = '0;
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b0;

        // reset state
        repeat (3) step();
        check_reset_outputs("reset");

        // initial credits
        check_init_credits("init");

        // single flit held downstream
        push_flit(32'hA5A5_A5A5);
        check("one_valid",  32'(bus.valid_out),  32'd1);
        check("one_occ",    32'(bus.occupancy),  32'd1);
        check("one_data",   bus.data_out,        32'hA5A5_A5A5);
        check("one_nocred", 32'(bus.credit_out), 32'd0);
        step();
        check("one_nocred2", 32'(bus.credit_out), 32'd0);
        bus.ready_out = 1'b1;
        step();
        bus.ready_out = 1'b0;
        check("one_pop_occ",   32'(bus.occupancy),  32'd0);
        check("one_cred_n",    32'(bus.credit_out), 32'd0);
        step();
        check("one_cred_n1",   32'(bus.credit_out), 32'd1);
        step();
        check("one_cred_n2",   32'(bus.credit_out), 32'd0);

        // fill 0..7 then drain
        for (int i = 0; i < DEPTH; i++) push_flit(32'(i));
        check("fill_occ",   32'(bus.occupancy), 32'd8);
        check("fill_valid", 32'(bus.valid_out), 32'd1);
        bus.ready_out = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            check("drain_data", bus.data_out, 32'(k));
            step();
            check("drain_credit", 32'(bus.credit_out), (k != 0) ? 32'd1 : 32'd0);
        end
        bus.ready_out = 1'b0;
        check("drain_occ",   32'(bus.occupancy), 32'd0);
        check("drain_valid", 32'(bus.valid_out), 32'd0);
        step();
        check("drain_last_credit", 32'(bus.credit_out), 32'd1);
        step();
        check("drain_credit_off",  32'(bus.credit_out), 32'd0);

        // streaming at occupancy 4
        for (int i = 0; i < 4; i++) push_flit(32'(100 + i));
        check("stream_occ0", 32'(bus.occupancy), 32'd4);
        bus.valid_in  = 1'b1;
        bus.ready_out = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.data_in = 32'(104 + i);
            check("stream_data", bus.data_out, 32'(100 + i));
            step();
            check("stream_occ", 32'(bus.occupancy), 32'd4);
            check("stream_credit", 32'(bus.credit_out), (i != 0) ? 32'd1 : 32'd0);
        end
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b0;
        step();
        check("stream_tail_credit", 32'(bus.credit_out), 32'd1);
        step();
        check("stream_credit_off",  32'(bus.credit_out), 32'd0);
        bus.ready_out = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("stream_flush", bus.data_out, 32'(120 + i));
            step();
        end
        bus.ready_out = 1'b0;
        repeat (6) step();
        check("stream_idle_occ",    32'(bus.occupancy),  32'd0);
        check("stream_idle_credit", 32'(bus.credit_out), 32'd0);

        // write while full
        for (int i = 0; i < DEPTH; i++) push_flit(32'(200 + i));
        check("ovf_pre", 32'(bus.overflow), 32'd0);
        push_flit(32'hDEAD_BEEF);
        check("ovf_occ",  32'(bus.occupancy), 32'd8);
        check("ovf_flag", 32'(bus.overflow),  32'(exp_ovf));
        step();
        check("ovf_sticky", 32'(bus.overflow), 32'(exp_ovf));
        bus.ready_out = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("ovf_drain", bus.data_out, 32'(200 + i));
            step();
        end
        bus.ready_out = 1'b0;
        check("ovf_empty",   32'(bus.occupancy), 32'd0);
        check("ovf_sticky2", 32'(bus.overflow),  32'(exp_ovf));
        repeat (10) step();

        // reset mid-operation
        for (int i = 0; i < 7; i++) push_flit(32'(300 + i));
        bus.ready_out = 1'b1;
        repeat (2) step();
        bus.ready_out = 1'b0;
        check("mid_occ", 32'(bus.occupancy), 32'd5);
        rst = 1'b1;
        step();
        check_reset_outputs("mid_reset");
        check_init_credits("reinit");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
